// File: rtl/adc_xcorr_if.sv
// Host/ADC-side bundle for adc_xcorr_engine: sample capture, baseline/coefficient
// writes, detect configuration and result outputs.
interface adc_xcorr_if #(
    parameter int NCH    = 8,
    parameter int ADC_W  = 12,
    parameter int DEPTH  = 5,
    parameter int COEF_W = 18
) ();
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ADDR_W = (NCH * DEPTH > 1) ? $clog2(NCH * DEPTH) : 1;

    logic                     sample_valid;
    logic [ADC_W-1:0]         sample_data;
    logic [CH_W-1:0]          sample_ch;
    logic                     base_wr;
    logic [CH_W-1:0]          base_ch;
    logic [ADC_W-1:0]         base_val;
    logic                     coef_wr;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic [NCH-1:0]           ch_mask;
    logic signed [31:0]       threshold;
    logic                     host_detect;
    logic signed [31:0]       cc;
    logic                     cc_valid;
    logic                     busy;
    logic                     detected;
    logic                     overrun;

    modport master (
        output sample_valid, sample_data, sample_ch,
        output base_wr, base_ch, base_val,
        output coef_wr, coef_addr, coef_data,
        output ch_mask, threshold, host_detect,
        input  cc, cc_valid, busy, detected, overrun
    );

    modport slave (
        input  sample_valid, sample_data, sample_ch,
        input  base_wr, base_ch, base_val,
        input  coef_wr, coef_addr, coef_data,
        input  ch_mask, threshold, host_detect,
        output cc, cc_valid, busy, detected, overrun
    );
endinterface

// File: rtl/adc_xcorr_engine.sv
// Multi-channel ADC cross-correlation: baseline-corrected per-channel history, frame
// snapshot, time-multiplexed MAC against template coefficients, saturated score and detect.
module adc_xcorr_engine #(
    parameter int NCH     = 8,
    parameter int ADC_W   = 12,
    parameter int DEPTH   = 5,
    parameter int COEF_W  = 18,
    parameter int ACC_W   = 40,
    parameter int SHIFT   = 6,
    parameter int HOLDOFF = 16
) (
    input logic        clk,
    input logic        reset_n,
    adc_xcorr_if.slave bus
);
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NTAP   = NCH * DEPTH;
    localparam int ADDR_W = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int TAP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int D_W    = ADC_W + 1;
    localparam int PROD_W = D_W + COEF_W;
    localparam int HO_W   = $clog2(HOLDOFF + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [ACC_W-1:0] CC_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [ACC_W-1:0] CC_MIN = {{(ACC_W-31){1'b1}}, 31'h0};

    function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] a);
        if (a > CC_MAX)      return 32'h7FFF_FFFF;
        else if (a < CC_MIN) return 32'h8000_0000;
        else                 return a[31:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [D_W-1:0]    d,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [PROD_W-1:0] p;
        logic signed [PROD_W-1:0] sh;
        p  = d * c;
        sh = p >>> SHIFT;
        return {{(ACC_W-PROD_W){sh[PROD_W-1]}}, sh};
    endfunction

    logic signed [D_W-1:0]    hist     [NCH][DEPTH];
    logic signed [D_W-1:0]    hist_nxt [NCH][DEPTH];
    logic signed [D_W-1:0]    snap     [NCH][DEPTH];
    logic        [ADC_W-1:0]  base     [NCH];
    logic signed [COEF_W-1:0] coef     [NTAP];

    logic [1:0]               state;
    logic [ADDR_W-1:0]        idx;
    logic [CH_W-1:0]          ch_cnt;
    logic [TAP_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  term;
    logic signed [31:0]       cc_q;
    logic                     cc_valid_q;
    logic                     overrun_q;
    logic                     detected_q;
    logic [HO_W-1:0]          hold;
    logic signed [D_W-1:0]    d_new;
    logic                     sample_ok;
    logic                     frame_end;
    logic                     last_step;

    assign sample_ok = bus.sample_valid && (int'(bus.sample_ch) < NCH);
    assign frame_end = bus.sample_valid && (bus.sample_ch == CH_W'(NCH - 1));
    assign last_step = (idx == ADDR_W'(NTAP - 1));

    // Baseline read here is the registered value, so a same-cycle baseline write is not seen.
    assign d_new = $signed({1'b0, bus.sample_data}) - $signed({1'b0, base[bus.sample_ch]});

    always_comb begin
        hist_nxt = hist;
        if (sample_ok) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_nxt[bus.sample_ch][k] = hist[bus.sample_ch][k-1];
            end
            hist_nxt[bus.sample_ch][0] = d_new;
        end
    end

    always_comb begin
        term = '0;
        if (bus.ch_mask[ch_cnt]) begin
            term = mac_term(snap[ch_cnt][tap_cnt], coef[idx]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist       <= '{default: '0};
            snap       <= '{default: '0};
            base       <= '{default: '0};
            coef       <= '{default: '0};
            state      <= S_IDLE;
            idx        <= '0;
            ch_cnt     <= '0;
            tap_cnt    <= '0;
            acc        <= '0;
            cc_q       <= '0;
            cc_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            hist       <= hist_nxt;
            cc_valid_q <= 1'b0;
            overrun_q  <= frame_end && (state != S_IDLE);
            if (bus.base_wr && (int'(bus.base_ch) < NCH)) begin
                base[bus.base_ch] <= bus.base_val;
            end
            if (bus.coef_wr && (int'(bus.coef_addr) < NTAP)) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end
            case (state)
                S_IDLE: begin
                    // Snapshot includes the frame-end sample itself.
                    if (frame_end) begin
                        snap    <= hist_nxt;
                        acc     <= '0;
                        idx     <= '0;
                        ch_cnt  <= '0;
                        tap_cnt <= '0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + term;
                    idx <= idx + ADDR_W'(1);
                    if (tap_cnt == TAP_W'(DEPTH - 1)) begin
                        tap_cnt <= '0;
                        ch_cnt  <= ch_cnt + CH_W'(1);
                    end else begin
                        tap_cnt <= tap_cnt + TAP_W'(1);
                    end
                    // Final term is folded in directly so the score is out during DONE.
                    if (last_step) begin
                        cc_q       <= sat32(acc + term);
                        cc_valid_q <= 1'b1;
                        ch_cnt     <= '0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            detected_q <= 1'b0;
            hold       <= '0;
        end else if (bus.threshold == 32'sd0) begin
            detected_q <= bus.host_detect;
            hold       <= '0;
        end else if (cc_valid_q) begin
            if (cc_q > bus.threshold) begin
                detected_q <= 1'b1;
                hold       <= HO_W'(HOLDOFF);
            end else if (hold != '0) begin
                hold <= hold - HO_W'(1);
            end else begin
                detected_q <= 1'b0;
            end
        end
    end

    assign bus.cc       = cc_q;
    assign bus.cc_valid = cc_valid_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.detected = detected_q;
    assign bus.overrun  = overrun_q;
endmodule
